vram_arbiter: RTL

- Shares one single-port video RAM between the QuokkaRv core data bus and the DVI scanline fetcher, both in the core clock domain.
- Serialises accesses through a three-state issue sequence.
- Gives the display fetcher weighted priority with a bounded burst, plus an urgent override, so the scanline buffer never underruns and the CPU is never starved.
- Sits between the core's memory-mapped VRAM window and the framebuffer BRAM, upstream of the DVI clock-domain crossing.

---
 rtl/vram_arbiter_if.sv | 38 +++
 rtl/vram_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Signal bundle for vram_arbiter: CPU port, display fetch port and RAM port.
// Names are from the arbiter's point of view; slave is the arbiter, master is the environment.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  i_cpu_req;
  logic                  i_cpu_we;
  logic [ADDR_W-1:0]     i_cpu_addr;
  logic [DATA_W-1:0]     i_cpu_wdata;
  logic [DATA_W/8-1:0]   i_cpu_wstrb;
  logic                  o_cpu_ack;
  logic [DATA_W-1:0]     o_cpu_rdata;
  logic                  i_disp_req;
  logic [ADDR_W-1:0]     i_disp_addr;
  logic                  i_disp_urgent;
  logic                  o_disp_ack;
  logic [DATA_W-1:0]     o_disp_rdata;
  logic                  o_ram_en;
  logic [DATA_W/8-1:0]   o_ram_we;
  logic [ADDR_W-1:0]     o_ram_addr;
  logic [DATA_W-1:0]     o_ram_wdata;
  logic [DATA_W-1:0]     i_ram_rdata;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_wstrb,
    input  i_disp_req, i_disp_addr, i_disp_urgent, i_ram_rdata,
    output o_cpu_ack, o_cpu_rdata, o_disp_ack, o_disp_rdata,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_wstrb,
    output i_disp_req, i_disp_addr, i_disp_urgent, i_ram_rdata,
    input  o_cpu_ack, o_cpu_rdata, o_disp_ack, o_disp_rdata,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the CPU data bus and the DVI scanline fetcher.
// Optional macro VRAM_ARB_URGENT_EN lets i_disp_urgent override the display burst limit.
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int DISP_BURST = 4
) (
  input  logic          i_clk_core,
  input  logic          i_rst_core,
  vram_arbiter_if.slave vram
);
  localparam int STRB_W = DATA_W / 8;
  localparam int RUN_W  = $clog2(DISP_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DISP_BURST);

  typedef enum logic [1:0] {ARB, ISSUE, RESP} state_e;

  state_e              state_q;
  logic [RUN_W-1:0]    disp_run_q;
  logic                grant_disp_q;
  logic                ram_en_q;
  logic [STRB_W-1:0]   ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                cpu_ack_q;
  logic                disp_ack_q;

  logic                urgent;
  logic                grant_any_d;
  logic                grant_disp_d;
  logic [RUN_W-1:0]    disp_run_d;

`ifdef VRAM_ARB_URGENT_EN
  assign urgent = vram.i_disp_urgent;
`else
  logic unused_urgent;
  assign unused_urgent = vram.i_disp_urgent;
  assign urgent        = 1'b0;
`endif

  // Grant decision; only consumed while the FSM sits in ARB.
  always_comb begin
    grant_any_d  = vram.i_cpu_req | vram.i_disp_req;
    grant_disp_d = 1'b0;
    if (vram.i_disp_req && !vram.i_cpu_req) begin
      grant_disp_d = 1'b1;
    end else if (vram.i_disp_req && vram.i_cpu_req) begin
      grant_disp_d = urgent || (disp_run_q < RUN_MAX);
    end
    disp_run_d = disp_run_q;
    if (grant_disp_d) begin
      disp_run_d = (disp_run_q == RUN_MAX) ? disp_run_q : disp_run_q + 1'b1;
    end else if (grant_any_d) begin
      disp_run_d = '0;
    end
  end

  always_ff @(posedge i_clk_core) begin
    if (i_rst_core) begin
      state_q      <= ARB;
      disp_run_q   <= '0;
      grant_disp_q <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      disp_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          cpu_ack_q  <= 1'b0;
          disp_ack_q <= 1'b0;
          if (grant_any_d) begin
            state_q      <= ISSUE;
            disp_run_q   <= disp_run_d;
            grant_disp_q <= grant_disp_d;
            ram_en_q     <= 1'b1;
            ram_addr_q   <= grant_disp_d ? vram.i_disp_addr : vram.i_cpu_addr;
            // The display port is read-only, so its grants never carry strobes.
            ram_we_q     <= (!grant_disp_d && vram.i_cpu_we) ? vram.i_cpu_wstrb : '0;
            if (!grant_disp_d) begin
              ram_wdata_q <= vram.i_cpu_wdata;
            end
          end
        end
        ISSUE: begin
          state_q    <= RESP;
          ram_en_q   <= 1'b0;
          ram_we_q   <= '0;
          cpu_ack_q  <= !grant_disp_q;
          disp_ack_q <= grant_disp_q;
        end
        RESP: begin
          state_q    <= ARB;
          cpu_ack_q  <= 1'b0;
          disp_ack_q <= 1'b0;
        end
        default: begin
          state_q    <= ARB;
          ram_en_q   <= 1'b0;
          ram_we_q   <= '0;
          cpu_ack_q  <= 1'b0;
          disp_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign vram.o_ram_en     = ram_en_q;
  assign vram.o_ram_we     = ram_we_q;
  assign vram.o_ram_addr   = ram_addr_q;
  assign vram.o_ram_wdata  = ram_wdata_q;
  assign vram.o_cpu_ack    = cpu_ack_q;
  assign vram.o_disp_ack   = disp_ack_q;
  // RAM read data arrives in the RESP cycle, aligned with the ack pulse.
  assign vram.o_cpu_rdata  = vram.i_ram_rdata;
  assign vram.o_disp_rdata = vram.i_ram_rdata;
endmodule
